fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Parametrised instruction fetch unit and circular byte buffer between the memory bus and the decoder.
//  Issues line-sized read requests and packs response beats into a ring buffer.
//  Presents a byte window, with its RIP, to the decoder and retires consumed bytes.
//  Adds redirect (flush and refetch) and in-flight drain that the single-entry fetch loop in Core lacks.
// PARAMETERS
//  BUF_BYTES    128  ring buffer capacity in bytes, power of 2
//  BEAT_BYTES   8    bytes per bus response beat, power of 2
//  LINE_BYTES   64   bytes per request; multiple of BEAT_BYTES, <= BUF_BYTES/2
//  WINDOW_BYTES 15   decode window width in bytes, <= BUF_BYTES - LINE_BYTES
//  REFILL_LVL   32   issue a request only while occupancy < REFILL_LVL; REFILL_LVL <= BUF_BYTES - LINE_BYTES
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous reset, active-low
//  entry          in   64             start RIP, sampled while reset is asserted
//  redirect_valid in   1              flush and refetch from redirect_rip
//  redirect_rip   in   64             new fetch RIP
//  req_cyc        out  1              read request valid, held until req_ack
//  req_addr       out  64             line-aligned request address
//  req_ack        in   1              request accepted
//  resp_cyc       in   1              response beat valid
//  resp_data      in   BEAT_BYTES*8   beat data, lowest-address byte in bits [7:0]
//  resp_ack       out  1              = resp_cyc (combinational)
//  window         out  WINDOW_BYTES*8 bytes from rd_ptr upward, wraps mod BUF_BYTES; byte i in bits [8i+7:8i]
//  window_rip     out  64             RIP of window byte 0
//  window_valid   out  1              occupancy >= WINDOW_BYTES
//  avail          out  $clog2(BUF_BYTES)+1  occupancy in bytes
//  consume        in   $clog2(WINDOW_BYTES)+1  bytes retired this cycle
// BEHAVIOUR
//  - Reset values:
//    - Outputs: req_cyc=0, avail=0, window_valid=0.
//    - Internal: rd_ptr=wr_ptr=0, state=IDLE.
//    - fetch_addr=entry&~(LINE_BYTES-1); window_rip=entry; skip=entry[log2(LINE)-1:0].
//  - FSM states: IDLE, WAIT, ACTIVE, DRAIN.
//    - IDLE->WAIT: req_cyc is set the cycle after occupancy < REFILL_LVL; req_cyc&&req_ack moves to WAIT.
//    - WAIT->ACTIVE: on the first beat.
//    - ACTIVE->IDLE: after LINE_BYTES/BEAT_BYTES beats, counted by beat_cnt.
//    - fetch_addr += LINE_BYTES when the last beat arrives.
//  - Beats are never backpressured; the REFILL_LVL rule guarantees space for one full line.
//  - Skip handling for each response beat:
//    - Beats wholly below skip are discarded.
//    - The beat holding the target byte is written at wr_ptr, and rd_ptr is pre-set to skip%BEAT_BYTES.
//    - That beat adds BEAT_BYTES - skip%BEAT_BYTES to occupancy.
//    - Later beats add BEAT_BYTES.
//  - Consume: rd_ptr += consume; window_rip += consume.
//    - Same-cycle beat and consume: occupancy += written - consume.
//    - consume > avail is illegal; a bench assertion fires and the RTL clamps consume to avail.
//  - Output latency: window, window_valid and avail are registered and reflect state after the clock edge.
//  - Pointers wrap mod BUF_BYTES. window_rip is 64-bit and wraps naturally.
//  - Redirect (takes priority over consume and beat write that cycle):
//    - Occupancy=0, pointers=0, window_rip=redirect_rip.
//    - fetch_addr and skip are reloaded from redirect_rip.
//    - In IDLE with req_cyc=1 and no req_ack: drop req_cyc next cycle.
//    - In WAIT or ACTIVE, or if req_ack arrives that cycle: go to DRAIN.
//    - DRAIN discards the remaining beats of the outstanding line, then goes to IDLE.
//    - A redirect during DRAIN only updates the target.
//  - Reset mid-transaction: all state clears immediately. The bus side must also be reset, because stray beats after reset are not tracked.
// TESTING
//  - Aligned start: entry=0x1000, beats 0..7 of bytes 0x00..0x3F ->
//    - req_addr=0x1000;
//    - avail=64 after 8 beats;
//    - window=0x00..0x0E; window_rip=0x1000.
//  - Unaligned start: entry=0x100B ->
//    - beat 0 discarded;
//    - avail=5 after beat 1; window_valid=0 until avail>=15;
//    - window byte0=0x0B; window_rip=0x100B.
//  - Wrap: with BUF_BYTES=128, consume 15/cycle ->
//    - second and third lines issue at 0x1040 and 0x1080;
//    - window is contiguous across the 127->0 boundary.
//  - Simultaneous events: beat and consume=7 in one cycle with avail=20 -> avail=21.
//  - Redirect in ACTIVE after 3 beats to 0x2000 ->
//    - 5 remaining beats are discarded in DRAIN;
//    - the next request is 0x2000; avail=0 until new beats arrive.
//  - Async reset asserted mid-WAIT -> req_cyc=0 and avail=0 immediately, with no clock edge.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch unit: issues line-sized reads, packs response beats into a
// byte ring and presents a registered decode window, with redirect and drain.
module fetch_buffer #(
    parameter int BUF_BYTES    = 128,
    parameter int BEAT_BYTES   = 8,
    parameter int LINE_BYTES   = 64,
    parameter int WINDOW_BYTES = 15,
    parameter int REFILL_LVL   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [63:0]                   entry,
    input  logic                          redirect_valid,
    input  logic [63:0]                   redirect_rip,
    output logic                          req_cyc,
    output logic [63:0]                   req_addr,
    input  logic                          req_ack,
    input  logic                          resp_cyc,
    input  logic [BEAT_BYTES*8-1:0]       resp_data,
    output logic                          resp_ack,
    output logic [WINDOW_BYTES*8-1:0]     window,
    output logic [63:0]                   window_rip,
    output logic                          window_valid,
    output logic [$clog2(BUF_BYTES):0]    avail,
    input  logic [$clog2(WINDOW_BYTES):0] consume
);
    localparam int PTR_W  = $clog2(BUF_BYTES);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BOFF_W = $clog2(BEAT_BYTES);
    localparam int LOFF_W = $clog2(LINE_BYTES);
    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [63:0] LINE_MASK = 64'(LINE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DRAIN} state_t;

    state_t                    state;
    logic [63:0]               fetch_addr;
    logic [LOFF_W-1:0]         skip;
    logic                      skip_vld;
    logic [BCNT_W-1:0]         beat_cnt;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          occ;
    logic [7:0]                mem [BUF_BYTES];

    logic [BCNT_W-1:0]         skip_beat;
    logic [PTR_W-1:0]          skip_off;
    logic                      beat_take;
    logic                      beat_last;
    logic                      beat_disc;
    logic                      beat_tgt;
    logic                      beat_wr;
    logic [CNT_W-1:0]          cons;
    logic [CNT_W-1:0]          written;
    logic [CNT_W-1:0]          occ_nxt;
    logic [PTR_W-1:0]          rd_nxt;
    logic [PTR_W-1:0]          wr_nxt;
    logic [PTR_W-1:0]          win_addr;
    logic [WINDOW_BYTES*8-1:0] win_nxt;

    assign req_addr = fetch_addr;
    assign resp_ack = resp_cyc;
    assign avail    = occ;

    // skip is the target byte offset inside the first line after reset/redirect
    assign skip_beat = BCNT_W'(skip >> BOFF_W);
    assign skip_off  = PTR_W'(skip) & PTR_W'(BEAT_BYTES - 1);

    assign beat_take = resp_cyc && (state == WAIT || state == ACTIVE);
    assign beat_last = (beat_cnt == BCNT_W'(NBEATS - 1));
    assign beat_disc = skip_vld && (beat_cnt < skip_beat);
    assign beat_tgt  = skip_vld && (beat_cnt == skip_beat);
    assign beat_wr   = beat_take && !redirect_valid && !beat_disc;

    always_comb begin
        cons    = (CNT_W'(consume) > occ) ? occ : CNT_W'(consume);
        written = '0;
        if (beat_wr)
            written = beat_tgt ? CNT_W'(BEAT_BYTES) - CNT_W'(skip_off) : CNT_W'(BEAT_BYTES);
        if (redirect_valid) begin
            occ_nxt = '0;
            rd_nxt  = '0;
            wr_nxt  = '0;
        end else begin
            occ_nxt = occ + written - cons;
            // first written byte of the target beat becomes the read point
            rd_nxt  = (beat_wr && beat_tgt) ? wr_ptr + skip_off : rd_ptr + cons[PTR_W-1:0];
            wr_nxt  = beat_wr ? wr_ptr + PTR_W'(BEAT_BYTES) : wr_ptr;
        end
    end

    // Window is built from post-edge state, so this cycle's beat is bypassed in.
    always_comb begin
        win_nxt  = '0;
        win_addr = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            win_addr = rd_nxt + PTR_W'(i);
            if (beat_wr && win_addr[PTR_W-1:BOFF_W] == wr_ptr[PTR_W-1:BOFF_W])
                win_nxt[8*i +: 8] = resp_data[{win_addr[BOFF_W-1:0], 3'b000} +: 8];
            else
                win_nxt[8*i +: 8] = mem[win_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            for (int j = 0; j < BEAT_BYTES; j++)
                mem[wr_ptr + PTR_W'(j)] <= resp_data[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_cyc    <= 1'b0;
            beat_cnt   <= '0;
            fetch_addr <= entry & ~LINE_MASK;
            skip       <= entry[LOFF_W-1:0];
            skip_vld   <= 1'b1;
        end else begin
            if (redirect_valid) begin
                fetch_addr <= redirect_rip & ~LINE_MASK;
                skip       <= redirect_rip[LOFF_W-1:0];
                skip_vld   <= 1'b1;
            end else begin
                if (beat_take && beat_last)
                    fetch_addr <= fetch_addr + 64'(LINE_BYTES);
                if (beat_take && beat_tgt)
                    skip_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_cyc && req_ack) begin
                        req_cyc  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= redirect_valid ? DRAIN : WAIT;
                    end else if (redirect_valid) begin
                        req_cyc <= 1'b0;
                    end else if (!req_cyc && occ < CNT_W'(REFILL_LVL)) begin
                        req_cyc <= 1'b1;
                    end
                end
                WAIT, ACTIVE: begin
                    if (resp_cyc) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BCNT_W'(1);
                            state    <= redirect_valid ? DRAIN : ACTIVE;
                        end
                    end else if (redirect_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // beats of the abandoned line are counted out and dropped
                    if (resp_cyc) begin
                        if (beat_last) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BCNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            window_rip   <= entry;
            window       <= '0;
            window_valid <= 1'b0;
        end else begin
            rd_ptr       <= rd_nxt;
            wr_ptr       <= wr_nxt;
            occ          <= occ_nxt;
            window_rip   <= redirect_valid ? redirect_rip : window_rip + 64'(cons);
            window       <= win_nxt;
            window_valid <= (occ_nxt >= CNT_W'(WINDOW_BYTES));
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic checked
// against a byte-stream model (window = memory bytes from rip, avail = end - rip).
module tb_fetch_buffer;
    localparam int BUF_BYTES    = 128;
    localparam int BEAT_BYTES   = 8;
    localparam int LINE_BYTES   = 64;
    localparam int WINDOW_BYTES = 15;
    localparam int REFILL_LVL   = 32;
    localparam int NBEATS       = LINE_BYTES / BEAT_BYTES;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [63:0]               entry = '0;
    logic                      redirect_valid = 1'b0;
    logic [63:0]               redirect_rip = '0;
    logic                      req_cyc;
    logic [63:0]               req_addr;
    logic                      req_ack = 1'b0;
    logic                      resp_cyc = 1'b0;
    logic [BEAT_BYTES*8-1:0]   resp_data = '0;
    logic                      resp_ack;
    logic [WINDOW_BYTES*8-1:0] window;
    logic [63:0]               window_rip;
    logic                      window_valid;
    logic [7:0]                avail;
    logic [4:0]                consume = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_rip, m_end, m_next;
    bit          ln_vld, ln_stale, acked;
    logic [63:0] ln_addr;
    int          ln_beat;
    logic [63:0] lines[$];

    always #5 clk = ~clk;

    fetch_buffer #(
        .BUF_BYTES(BUF_BYTES), .BEAT_BYTES(BEAT_BYTES), .LINE_BYTES(LINE_BYTES),
        .WINDOW_BYTES(WINDOW_BYTES), .REFILL_LVL(REFILL_LVL)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_rip(redirect_rip),
        .req_cyc(req_cyc), .req_addr(req_addr), .req_ack(req_ack),
        .resp_cyc(resp_cyc), .resp_data(resp_data), .resp_ack(resp_ack),
        .window(window), .window_rip(window_rip), .window_valid(window_valid),
        .avail(avail), .consume(consume)
    );

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h10;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // consume beyond avail is illegal stimulus
    always @(posedge clk) begin
        if (reset) begin
            n_cmp++;
            assert (consume <= avail) else begin
                n_bad++;
                $error("FAIL consume_legal: observed consume %0d with avail %0d", consume, avail);
            end
        end
    end

    task automatic drive(input bit beat, input bit ack, input int cons, input bit redir,
                         input logic [63:0] rip);
        resp_cyc  = beat && ln_vld;
        resp_data = '0;
        if (ln_vld)
            for (int j = 0; j < BEAT_BYTES; j++)
                resp_data[8*j +: 8] = mem_byte(ln_addr + 64'(ln_beat * BEAT_BYTES + j));
        acked   = ack && req_cyc;
        req_ack = acked;
        if (acked) chk("req_addr", 128'(req_addr), 128'(m_next));
        consume        = 5'(cons);
        redirect_valid = redir;
        redirect_rip   = rip;
    endtask

    task automatic model_edge();
        logic [63:0] b;
        if (resp_cyc) begin
            b = ln_addr + 64'(ln_beat * BEAT_BYTES);
            if (!ln_stale && !redirect_valid && $signed(b + 64'(BEAT_BYTES) - m_end) > 0)
                m_end = b + 64'(BEAT_BYTES);
            ln_beat++;
            if (ln_beat == NBEATS) ln_vld = 1'b0;
        end
        if (!redirect_valid) m_rip = m_rip + 64'(consume);
        if (acked) begin
            lines.push_back(m_next);
            ln_vld   = 1'b1;
            ln_addr  = m_next;
            ln_beat  = 0;
            ln_stale = 1'b0;
            m_next   = m_next + 64'(LINE_BYTES);
        end
        if (redirect_valid) begin
            m_rip    = redirect_rip;
            m_end    = redirect_rip;
            m_next   = redirect_rip & ~64'(LINE_BYTES - 1);
            ln_stale = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [63:0]               av;
        logic [WINDOW_BYTES*8-1:0] ew, mk;
        av = m_end - m_rip;
        ew = '0;
        mk = '0;
        for (int i = 0; i < WINDOW_BYTES; i++)
            if (64'(i) < av) begin
                ew[8*i +: 8] = mem_byte(m_rip + 64'(i));
                mk[8*i +: 8] = 8'hFF;
            end
        chk("avail", 128'(avail), 128'(av));
        chk("window_valid", 128'(window_valid), 128'(av >= 64'(WINDOW_BYTES)));
        chk("window_rip", 128'(window_rip), 128'(m_rip));
        chk("window", 128'(window & mk), 128'(ew));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b0;
        entry = e;
        drive(0, 0, 0, 0, 64'h0);
        #1;
        chk("rst_req_cyc", 128'(req_cyc), 128'(0));
        chk("rst_avail", 128'(avail), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_window_valid", 128'(window_valid), 128'(0));
        chk("rst_window_rip", 128'(window_rip), 128'(e));
        m_rip    = e;
        m_end    = e;
        m_next   = e & ~64'(LINE_BYTES - 1);
        ln_vld   = 1'b0;
        ln_stale = 1'b0;
        lines.delete();
        reset    = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (!req_cyc && k < 40) begin
            drive(0, 0, 0, 0, 64'h0);
            cycle();
            k++;
        end
        chk(tag, 128'(req_cyc), 128'(1));
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 64'h0);
            cycle();
        end
    endtask

    initial begin
        logic [WINDOW_BYTES*8-1:0] exp_w;
        logic [63:0]               av, tgt;
        int                        mc, k;

        // aligned start
        do_reset(64'h1000);
        wait_req("aligned_req");
        chk("aligned_req_addr", 128'(req_addr), 128'(64'h1000));
        drive(0, 1, 0, 0, 64'h0); cycle();
        beats(NBEATS);
        for (int i = 0; i < WINDOW_BYTES; i++) exp_w[8*i +: 8] = 8'(i);
        chk("aligned_avail", 128'(avail), 128'(64));
        chk("aligned_window", 128'(window), 128'(exp_w));
        chk("aligned_rip", 128'(window_rip), 128'(64'h1000));

        // unaligned start: beat 0 dropped, beat 1 lands with 5 usable bytes
        do_reset(64'h100B);
        wait_req("unal_req");
        drive(0, 1, 0, 0, 64'h0); cycle();
        beats(1);
        chk("unal_beat0_avail", 128'(avail), 128'(0));
        beats(1);
        chk("unal_avail", 128'(avail), 128'(5));
        chk("unal_valid", 128'(window_valid), 128'(0));
        chk("unal_byte0", 128'(window[7:0]), 128'(8'h0B));
        chk("unal_rip", 128'(window_rip), 128'(64'h100B));
        beats(2);
        chk("unal_avail21", 128'(avail), 128'(21));
        chk("unal_valid21", 128'(window_valid), 128'(1));

        // beat and consume in the same cycle
        do_reset(64'h1000);
        wait_req("sim_req");
        drive(0, 1, 0, 0, 64'h0); cycle();
        beats(3);
        drive(0, 0, 4, 0, 64'h0); cycle();
        chk("sim_avail20", 128'(avail), 128'(20));
        drive(1, 0, 7, 0, 64'h0); cycle();
        chk("sim_avail21", 128'(avail), 128'(21));

        // redirect in ACTIVE after 3 beats
        do_reset(64'h1000);
        wait_req("redir_first_req");
        drive(0, 1, 0, 0, 64'h0); cycle();
        beats(3);
        drive(0, 0, 0, 1, 64'h2000); cycle();
        chk("redir_avail", 128'(avail), 128'(0));
        for (int i = 0; i < NBEATS - 3; i++) begin
            beats(1);
            chk("drain_avail", 128'(avail), 128'(0));
            chk("drain_no_req", 128'(req_cyc), 128'(0));
        end
        wait_req("redir_req");
        chk("redir_req_addr", 128'(req_addr), 128'(64'h2000));
        drive(0, 1, 0, 0, 64'h0); cycle();
        beats(2);
        chk("redir_byte0", 128'(window[7:0]), 128'(mem_byte(64'h2000)));

        // sustained consume of 15/cycle wraps the ring several times
        do_reset(64'h1000);
        for (int n = 0; n < 150; n++) begin
            av = m_end - m_rip;
            mc = (av > 64'd15) ? 15 : int'(av);
            drive(1, 1, mc, 0, 64'h0);
            cycle();
        end
        chk("wrap_line_count", 128'(lines.size() >= 4), 128'(1));
        chk("wrap_line1", 128'((lines.size() > 1) ? lines[1] : '1), 128'(64'h1040));
        chk("wrap_line2", 128'((lines.size() > 2) ? lines[2] : '1), 128'(64'h1080));

        // bring the unit into WAIT with bytes held, then reset asynchronously
        k = 0;
        while (ln_vld && k < 40) begin drive(1, 0, 0, 0, 64'h0); cycle(); k++; end
        k = 0;
        while (!req_cyc && k < 40) begin
            av = m_end - m_rip;
            mc = (av > 64'd16) ? 15 : ((av > 64'd1) ? int'(av) - 1 : 0);
            drive(0, 0, mc, 0, 64'h0);
            cycle();
            k++;
        end
        chk("wait_req_seen", 128'(req_cyc), 128'(1));
        drive(0, 1, 0, 0, 64'h0); cycle();
        chk("wait_avail_nonzero", 128'(avail != 8'd0), 128'(1));
        do_reset(64'h3000);

        // randomized traffic with occasional redirects, some near the top of the address space
        for (int n = 0; n < 3000; n++) begin
            av  = m_end - m_rip;
            mc  = (av > 64'd15) ? 15 : int'(av);
            tgt = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63))
                                              : 64'h4000 + 64'($urandom_range(0, 4095));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  int'($urandom_range(0, mc)), $urandom_range(0, 59) == 0, tgt);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
